pulse_emitter: RTL and testbench
================================

Name: pulse_emitter

Overview:
- Transmit-side counterpart of the lighthouse pulse capture path.
- Takes one 64-bit frame of sixteen 4-bit pulse-type codes and emits them serially as timed high pulses, each separated by a fixed low gap.
- Also mirrors the capture-side interface (next strobe plus duration bus), so it can drive the pulse buffer directly in loopback benches or act as a sensor emulator.

Parameters:
- CODE_W, 4: bits per pulse-type code.
- CODES, 16: codes per frame; frame width = CODE_W*CODES = 64.
- DUR_W, 16: width of the duration counter and duration bus.
- BASE_LEN, 3000: high length in clk cycles for code 0.
- STEP_LEN, 500: additional high cycles per code increment.
- GAP_LEN, 1000: low cycles after every pulse; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  frame word offered.
- in_ready  output  1  emitter can accept a frame.
- in_data  input  64  frame; nibble k = in_data[4*k+:4]; nibble 0 is sent first.
- pulse_out  output  1  serial pulse line, high during a pulse.
- next  output  1  one-cycle strobe on the first gap cycle after each pulse.
- duration  output  DUR_W  high length of the pulse just ended; valid while next=1, held otherwise.
- index  output  4  code position currently being emitted.
- busy  output  1  frame in progress.
- done  output  1  one-cycle strobe at end of frame.

Behaviour:
- Reset values (first cycle after rst sampled high): pulse_out=0, next=0, duration=0, index=0, busy=0, done=0, in_ready=1, state=IDLE.
- rst has priority over every other input, including mid-pulse. A frame in progress is abandoned with no next or done strobe. The latched word is cleared.
- States:
  - IDLE: in_ready=1, pulse_out=0. in_valid&&in_ready at edge E0 latches in_data, sets index=0 and goes to HIGH.
  - HIGH: pulse_out=1 for exactly len(code) cycles, where len(code) = BASE_LEN + code*STEP_LEN, computed at DUR_W width. Ends into GAP.
  - GAP: pulse_out=0 for exactly GAP_LEN cycles. First GAP cycle: next=1, duration=len(code). At the end of the last GAP cycle:
    - if index<CODES-1: increment index, go to HIGH;
    - otherwise: go to IDLE with done=1 for the first IDLE cycle.
- Latency: the first HIGH cycle is the cycle after E0. Frame length = sum(len(code_k)) + CODES*GAP_LEN cycles.
- busy=1 in HIGH and GAP only. in_ready=!busy, except as stated in the Optional Feature.
- in_valid while busy: ignored. No latching, and the in-flight frame is unaffected.
- in_valid in the done cycle: accepted, because the block is already in IDLE with in_ready=1.
- Width rule: BASE_LEN + (2^CODE_W-1)*STEP_LEN < 2^DUR_W is required. The default maximum, 10500, fits 16 bits. No saturation logic.
- Counters count down from len-1 / GAP_LEN-1 to 0, with no off-by-one: the high time measured at pulse_out equals the reported duration exactly.
- index wraps only via the return to 0 on frame start; it is never driven past CODES-1.

Optional Feature:
- Macro: PULSE_EMITTER_LOOP_EN.
- Defined:
  - After the last GAP cycle the block does not go to IDLE. It restarts at index 0 in HIGH on the next cycle, with done=1 coincident with that first HIGH cycle.
  - in_ready=1 during the final GAP_LEN cycles of a frame (index=CODES-1, state GAP).
  - A handshake in that window replaces the word for the next frame; otherwise the same word is replayed indefinitely.
  - Only rst returns the block to IDLE.
- Not defined: single-shot behaviour as above.
- Port list is identical in both builds.

Test Plan (BASE_LEN=4, STEP_LEN=2, GAP_LEN=3, DUR_W=8):
- Reset check: assert rst 2 cycles mid-frame -> next cycle pulse_out=0, busy=0, index=0, in_ready=1; no next or done strobe ever observed for the aborted frame.
- in_data=64'h0 accepted at cycle 0:
  - pulse_out high for cycles 1-4, low for 5-7;
  - 16 repeats, ending with the last gap at cycle 112;
  - done=1 only at cycle 113; 16 next strobes, each with duration=4.
- in_data=64'hFEDCBA9876543210:
  - pulse k high for 4+2k cycles;
  - duration at successive next strobes = 4, 6, 8 ... 34;
  - done 1+sum(4+2k)+48 = 353 cycles after accept.
- Second word 64'h1111... offered with in_valid held from cycle 10 of a frame -> in_ready=0 and ignored until the done cycle; accepted there; its first pulse is 6 cycles high.
- Loopback: pulse_emitter next/duration drive the pulse buffer's next/pulse with a BASE/STEP matching the recognizer thresholds -> buffer completes and its out equals the transmitted word.
- With PULSE_EMITTER_LOOP_EN, word 64'h0, no further in_valid:
  - second frame starts exactly 3 gap cycles after the last pulse;
  - done pulses once per 112 cycles;
  - a new word offered in the final gap window is the one emitted in the following frame.

Source files
------------

// File: rtl/pulse_emitter_if.sv
// Frame handshake and pulse/strobe bundle between a frame source and pulse_emitter.
// Latency: none, this is wiring only.
// Backpressure: in_valid/in_ready handshake on the frame word; the pulse outputs are never stalled.
interface pulse_emitter_if #(
    parameter int CODE_W = 4,
    parameter int CODES  = 16,
    parameter int DUR_W  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [CODE_W*CODES-1:0]   in_data;
    logic                      pulse_out;
    logic                      next;
    logic [DUR_W-1:0]          duration;
    logic [3:0]                index;
    logic                      busy;
    logic                      done;

    // Frame source / consumer side
    modport master (
        output in_valid, in_data,
        input  in_ready, pulse_out, next, duration, index, busy, done
    );

    // Emitter side
    modport slave (
        input  in_valid, in_data,
        output in_ready, pulse_out, next, duration, index, busy, done
    );
endinterface

// File: rtl/pulse_emitter.sv
// Serialises a frame of pulse-type codes into timed high pulses with fixed low gaps, mirroring next/duration.
// Latency: first high cycle is the cycle after the accepting edge; frame = sum(len) + CODES*GAP_LEN cycles.
// Backpressure: in_ready low while a frame is in flight (PULSE_EMITTER_LOOP_EN: high during the final gap).
module pulse_emitter #(
    parameter int CODE_W   = 4,
    parameter int CODES    = 16,
    parameter int DUR_W    = 16,
    parameter int BASE_LEN = 3000,
    parameter int STEP_LEN = 500,
    parameter int GAP_LEN  = 1000   // must be >= 1
) (
    input  logic           clk,
    input  logic           rst,
    pulse_emitter_if.slave bus
);
    localparam int                FRAME_W  = CODE_W * CODES;
    localparam logic [3:0]        LAST_IDX = 4'(CODES - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST = DUR_W'(GAP_LEN - 1);
    localparam logic [DUR_W-1:0]  ONE      = DUR_W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t              state;
    logic [DUR_W-1:0]    cnt;
    logic [FRAME_W-1:0]  word;
    logic                accept;
    logic [3:0]          nxt_idx;
    logic [CODE_W-1:0]   cur_code;
    logic [CODE_W-1:0]   nxt_code;

    // High length of a code; the width rule guarantees no overflow at DUR_W bits
    function automatic logic [DUR_W-1:0] pulse_len(input logic [CODE_W-1:0] code);
        return DUR_W'(BASE_LEN) + DUR_W'(code) * DUR_W'(STEP_LEN);
    endfunction

    assign accept  = bus.in_valid && bus.in_ready;
    assign nxt_idx = bus.index + 4'd1;

`ifdef PULSE_EMITTER_LOOP_EN
    logic [CODE_W-1:0] first_code;
`endif

    // Code currently being sent, the one after it, and the first code of a replayed frame
    always_comb begin
        cur_code = word[bus.index*CODE_W +: CODE_W];
        nxt_code = word[nxt_idx*CODE_W +: CODE_W];
`ifdef PULSE_EMITTER_LOOP_EN
        // A word accepted on the very last gap cycle must already drive the first pulse
        first_code = accept ? bus.in_data[CODE_W-1:0] : word[CODE_W-1:0];
`endif
    end

    // Sequencer: all outputs are registered; counters run len-1 .. 0 so high time equals duration
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            word          <= '0;
            bus.pulse_out <= 1'b0;
            bus.next      <= 1'b0;
            bus.duration  <= '0;
            bus.index     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.in_ready  <= 1'b1;
        end else begin
            bus.next <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        word          <= bus.in_data;
                        bus.index     <= '0;
                        cnt           <= pulse_len(bus.in_data[CODE_W-1:0]) - ONE;
                        state         <= HIGH;
                        bus.pulse_out <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.in_ready  <= 1'b0;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state         <= GAP;
                        bus.pulse_out <= 1'b0;
                        bus.next      <= 1'b1;
                        bus.duration  <= pulse_len(cur_code);
                        cnt           <= GAP_LAST;
`ifdef PULSE_EMITTER_LOOP_EN
                        // Open the replacement window for the whole final gap
                        if (bus.index == LAST_IDX) bus.in_ready <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                GAP: begin
`ifdef PULSE_EMITTER_LOOP_EN
                    if (accept) word <= bus.in_data;
`endif
                    if (cnt == '0) begin
                        if (bus.index != LAST_IDX) begin
                            bus.index     <= nxt_idx;
                            cnt           <= pulse_len(nxt_code) - ONE;
                            state         <= HIGH;
                            bus.pulse_out <= 1'b1;
                        end else begin
`ifdef PULSE_EMITTER_LOOP_EN
                            // Replay (or start the replacement word) straight away
                            bus.index     <= '0;
                            cnt           <= pulse_len(first_code) - ONE;
                            state         <= HIGH;
                            bus.pulse_out <= 1'b1;
                            bus.done      <= 1'b1;
                            bus.in_ready  <= 1'b0;
`else
                            // index stays at the last position until the next frame starts
                            state         <= IDLE;
                            bus.busy      <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            bus.done      <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_emitter.sv
// Self-checking bench for pulse_emitter with small timing constants and a cycle-position reference model.
// Latency: checks every cycle of each frame, including the done cycle.
// Backpressure: exercises in_valid held while busy and acceptance in the done / final-gap cycle.
module tb_pulse_emitter;
    localparam int BASE = 4;
    localparam int STEP = 2;
    localparam int GAP  = 3;
    localparam int DW   = 8;
    // {pulse_out, next, busy, done, in_ready, index[3:0], duration[7:0]}
    localparam logic [16:0] RST_V = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 8'd0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_emitter_if #(.CODE_W(4), .CODES(16), .DUR_W(DW)) bus ();

    pulse_emitter #(
        .CODE_W(4), .CODES(16), .DUR_W(DW),
        .BASE_LEN(BASE), .STEP_LEN(STEP), .GAP_LEN(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  last_dur;
    logic [16:0] obs;

    assign obs = {bus.pulse_out, bus.next, bus.busy, bus.done, bus.in_ready, bus.index, bus.duration};

    // High length of code k of word w
    function automatic int plen(input logic [63:0] w, input int k);
        return BASE + int'(w[4*k +: 4]) * STEP;
    endfunction

    // Cycles from first high cycle to last gap cycle
    function automatic int flen(input logic [63:0] w);
        int s = 0;
        for (int k = 0; k < 16; k++) s += plen(w, k) + GAP;
        return s;
    endfunction

    // Expected outputs c cycles after the accepting edge, found by walking the pulse/gap timeline
    function automatic logic [16:0] model(input logic [63:0] w, input int c,
                                          input logic [7:0] pd, input bit replay);
        int         t = 1;
        logic [7:0] d = pd;
        int         len;
        logic       rdy;
        for (int k = 0; k < 16; k++) begin
            len = plen(w, k);
            if (c < t + len) return {1'b1, 1'b0, 1'b1, replay && (c == 1), 1'b0, 4'(k), d};
            t += len;
            d = 8'(len);
            if (c < t + GAP) begin
`ifdef PULSE_EMITTER_LOOP_EN
                rdy = (k == 15);
`else
                rdy = 1'b0;
`endif
                return {1'b0, c == t, 1'b1, 1'b0, rdy, 4'(k), d};
            end
            t += GAP;
        end
        return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd15, d};
    endfunction

    task automatic check(input string tag, input logic [16:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("reset_1st", RST_V);
        tick();
        check("reset_2nd", RST_V);
        rst = 1'b0;
        last_dur = 8'd0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, RST_V);
            tick();
        end
    endtask

    // Offer w to an idle emitter; returns just after the accepting edge (cycle 1)
    task automatic start_frame(input logic [63:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Check every cycle of a frame; optionally raise in_valid with hold_w from cycle hold_c on
    task automatic check_frame(input logic [63:0] w, input bit replay,
                               input int hold_c, input logic [63:0] hold_w);
        int L = flen(w);
        int last;
`ifdef PULSE_EMITTER_LOOP_EN
        last = L;
`else
        last = L + 1;
`endif
        for (int c = 1; c <= last; c++) begin
            check($sformatf("frame_%h_c%0d", w, c), model(w, c, last_dur, replay));
            if (c == hold_c) begin
                bus.in_valid = 1'b1;
                bus.in_data  = hold_w;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        last_dur = 8'(plen(w, 15));
    endtask

    initial begin
        logic [63:0] w;
        logic [63:0] w1;
        w1 = {16{4'h1}};
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        last_dur = 8'd0;

        do_reset();
        idle_check("idle_after_reset", 3);

`ifdef PULSE_EMITTER_LOOP_EN
        // Replay of word 0, then a replacement word accepted in the final gap
        w = {32'($urandom), 32'($urandom)};
        start_frame(64'h0);
        check_frame(64'h0, 1'b0, 0, 64'h0);
        check_frame(64'h0, 1'b1, flen(64'h0) - 1, w);
        check_frame(w, 1'b1, 0, 64'h0);
        check_frame(w, 1'b1, 0, 64'h0);
`else
        // All-zero word: 16 pulses of 4 high / 3 low, done at cycle 113
        start_frame(64'h0);
        check_frame(64'h0, 1'b0, 0, 64'h0);

        // Rising codes, with a second word held from cycle 10 and taken in the done cycle
        start_frame(64'hFEDCBA9876543210);
        check_frame(64'hFEDCBA9876543210, 1'b0, 10, w1);
        check_frame(w1, 1'b0, 0, 64'h0);

        // Random words
        for (int i = 0; i < 3; i++) begin
            w = {32'($urandom), 32'($urandom)};
            start_frame(w);
            check_frame(w, 1'b0, 0, 64'h0);
        end
`endif

        // Reset in the middle of a pulse: the frame vanishes without next/done strobes
        w = {32'($urandom), 32'($urandom)};
        start_frame(w);
        for (int i = 0; i < 20 + int'($urandom_range(0, 15)); i++) tick();
        do_reset();
        idle_check("idle_after_abort", 40);

        // Normal operation resumes after the abort
        start_frame(64'hFEDCBA9876543210);
        check_frame(64'hFEDCBA9876543210, 1'b0, 0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
